uart_rx_deframer: RTL
=====================

Name: uart_rx_deframer

Overview:
Receive-side UART deframer between the raw serial input pin (ui_in[7]) and the processor's receive path. Synchronises the asynchronous line, detects 8N1 frames LSB-first with mid-bit sampling, and hands each byte to the processor over a valid/ready handshake with a one-byte holding register. Flags framing errors and overruns as single-cycle pulses.

Parameters:
CLKS_PER_BIT, 87, clock cycles per bit period (10 MHz / 115200); legal range 4..65535.
HALF_BIT, CLKS_PER_BIT/2 (integer divide), cycles from start-bit edge to start-bit sample point; derived, never overridden.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx  input  1  raw serial line, idle high, asynchronous to clk
rx_data  output  8  received byte, held stable while rx_valid=1
rx_valid  output  1  holding register contains an unconsumed byte
rx_ready  input  1  consumer accepts rx_data in a cycle where rx_valid=1
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst_n=0, asynchronous): both synchroniser flops=1, state=IDLE, bit counter=0, cycle counter=0, shift register=0, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0. Reset mid-frame abandons the frame; no partial byte is ever delivered.
- Synchroniser: two flops. rx_s is the second-flop output. All logic uses only rx_s.
- IDLE: on the first cycle rx_s=0 (t0), go to START and clear the cycle counter.
- START: on cycle t0+HALF_BIT, sample rx_s.
  - If 1: glitch. Return to IDLE. No flags.
  - If 0: go to DATA with bit index 0 and cycle counter cleared.
- DATA: bit k (k=0..7) is sampled at t0+HALF_BIT+(k+1)*CLKS_PER_BIT and shifted in LSB-first. After bit 7, go to STOP.
- STOP: sample at t0+HALF_BIT+9*CLKS_PER_BIT.
  - If 1: deliver the byte (see below), then go to IDLE.
  - If 0: pulse frame_err for one cycle, discard the byte, go to BRK_WAIT.
- BRK_WAIT: stay until rx_s=1, then go to IDLE. This prevents a held-low break from being decoded as 0x00 frames.
- Delivery, in the cycle after the stop sample:
  - If rx_valid=0, or rx_valid=1 and rx_ready=1 in the stop-sample cycle: load rx_data and set rx_valid=1.
  - Otherwise: pulse overrun for one cycle, drop the new byte, and leave rx_data/rx_valid unchanged.
- Handshake:
  - rx_valid clears in the cycle after rx_valid=1 and rx_ready=1, unless a new byte loads in that same cycle, in which case rx_valid stays 1 with the new data.
  - rx_ready while rx_valid=0 has no effect.
  - rx_data never changes while rx_valid=1 except on a simultaneous accept+load.
- Latency: rx_valid rises at pin-fall + 2 (synchroniser) + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles.
- Back-to-back frames: IDLE is re-entered half a bit before the stop bit ends. The next start edge is detected with no lost frame, provided the transmitter's bit rate is within ±4% of CLKS_PER_BIT.
- Counters wrap only through explicit clearing. The cycle counter width is clog2(CLKS_PER_BIT)+1.
- frame_err and overrun are registered and are never high in the same cycle.

Test Plan:
1. Reset with rx=1, CLKS_PER_BIT=8 -> all outputs 0, busy=0. Assert rst_n=0 mid-DATA -> busy=0 immediately, no rx_valid after release.
2. Send 0xA5 (8N1, 8 clk/bit), rx_ready=1 -> rx_data=0xA5 and rx_valid high for exactly 1 cycle, at pin-fall + 2+4+72+1 = 79 cycles; frame_err=0.
3. rx low for 3 cycles, then high -> START rejects it, no rx_valid, busy returns to 0 by cycle 7.
4. Send 0x3C with stop bit driven 0, then hold rx low 40 cycles -> one frame_err pulse, no rx_valid, busy stays 1 until rx returns high, then 0x55 is received correctly.
5. rx_ready=0; send 0x11 then 0x22 back-to-back -> rx_data=0x11, rx_valid=1, a single overrun pulse at the second stop, rx_data remains 0x11. Raise rx_ready -> rx_valid clears next cycle.
6. rx_ready=0; send 0x01, 0x02, 0x03, raising rx_ready for 1 cycle exactly at the second frame's stop-sample cycle -> 0x02 replaces 0x01 with rx_valid continuously high; 0x03 causes overrun.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receive deframer: synchronises the serial line, samples each bit at
// mid-period and hands completed bytes out through a one-byte valid/ready holding register.
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT) + 1;

    // The counter starts at 0 in the cycle after a clear, so a sample point
    // N cycles after the clearing cycle is reached when the count equals N-1.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK_WAIT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             cnt_clear;
    logic             shift_en;
    logic             stop_good;
    logic             stop_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if ((cnt == BIT_LAST) && (bit_idx == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    state_next = rx_s ? IDLE : BRK_WAIT;
                end
            end
            BRK_WAIT: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        cnt_clear = 1'b0;
        shift_en  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE:     cnt_clear = 1'b1;
            START:    cnt_clear = (cnt == HALF_LAST);
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_clear = 1'b1;
                    shift_en  = 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_clear = 1'b1;
                    stop_good = rx_s;
                    stop_bad  = ~rx_s;
                end
            end
            BRK_WAIT: cnt_clear = 1'b1;
            default:  cnt_clear = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Bit index only advances inside DATA and is explicitly returned to zero elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            if (state != DATA) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= (bit_idx == 3'd7) ? 3'd0 : bit_idx + 3'd1;
            end
            if (shift_en) begin
                shift <= {rx_s, shift[7:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (stop_good) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
